// File: rtl/ebr_burst_buf.sv
// Burst buffer: narrow write bursts into a word array, wide packed read bursts out
// through a counted read engine with valid/ready, last flag and abort.
module ebr_burst_buf #(
  parameter  int WR_WIDTH   = 8,
  parameter  int RATIO      = 4,
  parameter  int DEPTH      = 64,
  parameter  int BIG_ENDIAN = 0,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(DEPTH/RATIO) + 1,
  localparam int RD_WIDTH   = WR_WIDTH * RATIO
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_start,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic                i_wr_valid,
  input  logic [WR_WIDTH-1:0] i_wr_data,
  input  logic                i_rd_start,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic [LW-1:0]       i_rd_len,
  input  logic                i_rd_abort,
  input  logic                i_rd_ready,
  output logic                o_rd_valid,
  output logic [RD_WIDTH-1:0] o_rd_data,
  output logic                o_rd_last,
  output logic                o_rd_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic [WR_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, w_wr_addr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_remaining;
  logic [RD_WIDTH-1:0] r_rd_data, w_fetch_word;
  logic                r_rd_valid, r_rd_last, r_busy;
  state_t              r_state, w_next;
  logic                w_load, w_fetch, w_retire, w_abort;

  // ---------------- write side ----------------
  assign w_wr_addr = i_wr_start ? i_wr_addr : r_wr_ptr;

  always_ff @(posedge i_clk)
    if (i_wr_valid) r_mem[w_wr_addr] <= i_wr_data;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)           r_wr_ptr <= '0;
    else if (i_wr_valid) r_wr_ptr <= w_wr_addr + AW'(1);
    else if (i_wr_start) r_wr_ptr <= i_wr_addr;

  // Each lane computes its own address so a burst straddling the top of memory wraps per word.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    localparam int SLOT = (BIG_ENDIAN != 0) ? (RATIO - 1 - g) : g;
    logic [AW-1:0] w_addr;
    assign w_addr = r_rd_ptr + AW'(g);
    assign w_fetch_word[SLOT*WR_WIDTH +: WR_WIDTH] = r_mem[w_addr];
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_fetch  = 1'b0;
    w_retire = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_rd_start && !i_rd_abort && i_rd_len != '0) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      S_RUN:
        if (i_rd_abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if ((!r_rd_valid || i_rd_ready) && r_remaining != '0) begin
          w_fetch = 1'b1;
          if (r_remaining == LW'(1)) w_next = S_DRAIN;
        end
      S_DRAIN:
        if (i_rd_abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (i_rd_ready) begin
          w_retire = 1'b1;
          w_next   = S_IDLE;
        end
      default: w_next = S_IDLE;
    endcase
  end

  // Fetch reads r_mem before this edge's write lands, so a same-address collision returns old data.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      if (w_load) begin
        r_rd_ptr    <= i_rd_addr;
        r_remaining <= i_rd_len;
      end
      if (w_fetch) begin
        r_rd_data   <= w_fetch_word;
        r_rd_valid  <= 1'b1;
        r_rd_last   <= (r_remaining == LW'(1));
        r_rd_ptr    <= r_rd_ptr + AW'(RATIO);
        r_remaining <= r_remaining - LW'(1);
      end
      if (w_retire) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
      if (w_abort) begin
        r_rd_valid  <= 1'b0;
        r_rd_last   <= 1'b0;
        r_rd_data   <= '0;
        r_remaining <= '0;
      end
    end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_last  = r_rd_last;
  assign o_rd_busy  = r_busy;

endmodule

// File: tb/tb_ebr_burst_buf.sv
// Random + directed bench for ebr_burst_buf; little- and big-endian instances share stimulus
// and are checked against a byte-array model of the buffer.
module tb_ebr_burst_buf;
  localparam int W = 8, R = 4, D = 64, AW = 6, LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_start, wr_valid, rd_start, rd_abort, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data;
  logic [LW-1:0] rd_len;
  logic          v0, v1, l0, l1, b0, b1;
  logic [31:0]   d0, d1;

  always #5 clk = ~clk;

  ebr_burst_buf #(.WR_WIDTH(W), .RATIO(R), .DEPTH(D), .BIG_ENDIAN(0)) u_le (
    .i_clk(clk), .i_rst(rst), .i_wr_start(wr_start), .i_wr_addr(wr_addr),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_rd_start(rd_start),
    .i_rd_addr(rd_addr), .i_rd_len(rd_len), .i_rd_abort(rd_abort),
    .i_rd_ready(rd_ready), .o_rd_valid(v0), .o_rd_data(d0), .o_rd_last(l0),
    .o_rd_busy(b0));

  ebr_burst_buf #(.WR_WIDTH(W), .RATIO(R), .DEPTH(D), .BIG_ENDIAN(1)) u_be (
    .i_clk(clk), .i_rst(rst), .i_wr_start(wr_start), .i_wr_addr(wr_addr),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_rd_start(rd_start),
    .i_rd_addr(rd_addr), .i_rd_len(rd_len), .i_rd_abort(rd_abort),
    .i_rd_ready(rd_ready), .o_rd_valid(v1), .o_rd_data(d1), .o_rd_last(l1),
    .o_rd_busy(b1));

  int         n_vec = 0, n_err = 0;
  logic [7:0] mm [D];
  int         wp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int addr, input int k, input bit be);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < R; i++)
      w[(be ? (R-1-i) : i)*8 +: 8] = mm[(addr + R*k + i) % D];
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_v0"}, v0, 0); chk({tag, "_v1"}, v1, 0);
    chk({tag, "_l0"}, l0, 0); chk({tag, "_l1"}, l1, 0);
    chk({tag, "_b0"}, b0, 0); chk({tag, "_b1"}, b1, 0);
  endtask

  // base < 0 selects random data, otherwise bytes base, base+1, ...
  task automatic write_burst(input int addr, input int n, input int base, input bit gaps);
    bit started = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      wr_start = 1; wr_addr = AW'(addr); tick; wr_start = 0; started = 1;
    end
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick;
      wr_valid = 1;
      wr_start = !started;
      wr_addr  = AW'(addr);
      wr_data  = (base < 0) ? 8'($urandom) : 8'(base + k);
      mm[(addr + k) % D] = wr_data;
      started = 1;
      tick;
      wr_valid = 0; wr_start = 0;
    end
    wp = (addr + n) % D;
  endtask

  task automatic write_cont(input logic [7:0] d);
    wr_valid = 1; wr_data = d;
    mm[wp] = d; wp = (wp + 1) % D;
    tick;
    wr_valid = 0;
  endtask

  // stall: ready held low for the first `stall` cycles with valid; abort_after < 0 disables abort
  task automatic read_burst(input int addr, input int len, input int stall, input int rdy_pct,
                            input int abort_after, input bit noise);
    int idx = 0, cyc = 1, stalls = stall;
    bit rdy, aborted = 0;
    rd_start = 1; rd_addr = AW'(addr); rd_len = LW'(len); rd_ready = 0;
    tick;
    rd_start = 0;
    if (len == 0) begin
      chk_quiet("len0_a"); tick; chk_quiet("len0_b");
      return;
    end
    chk("start_busy", b0, 1);
    while (idx < len) begin
      if (cyc > 20*len + 40) begin
        n_vec++; n_err++;
        $display("FAIL timeout idx=%0d exp_len=%0d", idx, len);
        rd_abort = 1; rd_start = 0; tick; rd_abort = 0;
        aborted = 1;
        break;
      end
      if (idx == abort_after) begin
        rd_abort = 1; rd_ready = $urandom_range(0, 1); tick; rd_abort = 0;
        chk_quiet("abort");
        chk("abort_d0", d0, 0); chk("abort_d1", d1, 0);
        aborted = 1;
        break;
      end
      chk("valid0", v0, cyc >= 2); chk("valid1", v1, cyc >= 2);
      chk("busy", b0 & b1, 1);
      if (cyc >= 2) begin
        chk("data_le", d0, exp_word(addr, idx, 0));
        chk("data_be", d1, exp_word(addr, idx, 1));
        chk("last0", l0, idx == len-1); chk("last1", l1, idx == len-1);
      end
      if (cyc >= 2 && stalls > 0) begin rdy = 0; stalls--; end
      else rdy = ($urandom_range(0, 99) < rdy_pct);
      rd_ready = rdy;
      if (noise) begin
        rd_start = ($urandom_range(0, 5) == 0);
        rd_addr  = AW'($urandom);
        rd_len   = LW'($urandom);
      end
      tick;
      if (cyc >= 2 && rdy) idx++;
      cyc++;
    end
    rd_start = 0; rd_ready = 0;
    if (!aborted) chk_quiet("done");
  endtask

  initial begin
    rst = 1; wr_start = 0; wr_addr = '0; wr_valid = 0; wr_data = '0;
    rd_start = 0; rd_addr = '0; rd_len = '0; rd_abort = 0; rd_ready = 0;
    #1;
    chk_quiet("reset"); chk("reset_d0", d0, 0); chk("reset_d1", d1, 0);
    tick; tick;
    rst = 0;
    tick;
    chk_quiet("post_reset");

    write_burst(0, D, -1, 0);

    // bytes 0x11..0x18 at 4 -> LE 0x14131211/0x18171615, BE 0x11121314/0x15161718
    write_burst(4, 8, 8'h11, 0);
    read_burst(4, 2, 0, 100, -1, 0);

    // write wraps the pointer; continuation write then lands at address 2
    write_burst(62, 4, 8'hA0, 0);
    write_cont(8'h5C);
    read_burst(62, 1, 0, 100, -1, 0);
    read_burst(0, 1, 0, 100, -1, 0);
    read_burst(61, 2, 0, 100, -1, 0);

    read_burst(8, 3, 3, 100, -1, 0);

    read_burst(0, 8, 0, 100, 2, 0);
    read_burst(5, 0, 0, 100, -1, 0);

    // asynchronous reset in the middle of a burst
    rd_start = 1; rd_addr = 6'd16; rd_len = 5'd8; rd_ready = 0;
    tick;
    rd_start = 0;
    tick;
    chk("pre_rst_valid", v0, 1);
    #2 rst = 1;
    #1;
    chk_quiet("async_rst"); chk("async_rst_d0", d0, 0); chk("async_rst_d1", d1, 0);
    @(posedge clk); #1;
    rst = 0;
    wp = 0;
    tick;
    chk_quiet("rst_release");
    write_cont(8'h77);
    read_burst(0, 1, 0, 100, -1, 0);

    for (int it = 0; it < 30; it++) begin
      write_burst($urandom_range(0, D-1), $urandom_range(1, 12), -1, 1);
      if ($urandom_range(0, 2) == 0) write_cont(8'($urandom));
      begin
        int len = $urandom_range(0, 31);
        int ab  = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len-1) : -1;
        read_burst($urandom_range(0, D-1), len, $urandom_range(0, 2),
                   $urandom_range(30, 100), ab, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
